// File: rtl/spi_adc_rx_multi.sv
// spi_adc_rx_multi: shared-CS/SCLK reader for NUM_CH AD7276-class ADCs, all channels emitted as one AXI-Stream beat
module spi_adc_rx_multi #(
    parameter int NUM_CH     = 2,
    parameter int ADC_BITS   = 12,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 2,
    parameter int SCLK_DIV   = 2,
    parameter int PKT_LEN    = 256
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_enable,
    input  logic [NUM_CH-1:0]            i_data,
    output logic                         o_cs,
    output logic                         o_sclk,
    input  logic [31:0]                  i_sample_div,
    output logic [31:0]                  o_sample_div_eff,
    output logic [NUM_CH*ADC_BITS-1:0]   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         o_overrun,
    input  logic                         i_clr_overrun,
    output logic                         o_busy
);
    localparam int MIN_DIV = 2 * SCLK_DIV * FRAME_BITS + 4;
    localparam int PW      = $clog2(2 * SCLK_DIV);
    localparam int BW      = $clog2(FRAME_BITS + 1);
    localparam int KW      = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
    localparam int CAP     = LEAD_BITS + ADC_BITS;

    typedef enum logic [1:0] {IDLE, CONVERT, QUIET} state_t;

    state_t                       state, state_nxt;
    logic [31:0]                  div_cnt;
    logic [PW-1:0]                ph;
    logic [BW-1:0]                bc;
    logic [KW-1:0]                beat;
    logic [ADC_BITS-1:0]          sh [NUM_CH];
    logic [NUM_CH*ADC_BITS-1:0]   sample;
    logic                         tick, period_end, last_bit, quiet_end, shift, load, hs, last_beat;

    assign o_sample_div_eff = (i_sample_div >= 32'(MIN_DIV)) ? i_sample_div : 32'(MIN_DIV);
    assign tick       = div_cnt == o_sample_div_eff - 32'd1;
    assign period_end = ph == PW'(2 * SCLK_DIV - 1);
    assign last_bit   = bc == BW'(FRAME_BITS - 1);
    assign quiet_end  = ph == PW'(1);
    // Only bits up to the sample LSB are kept; lead bits fall off the top, trailing bits never enter
    assign shift      = state == CONVERT && ph == PW'(SCLK_DIV) && bc < BW'(CAP);
    assign load       = state == QUIET && quiet_end;
    assign hs         = m_axis_tvalid && m_axis_tready;
    assign last_beat  = beat == KW'(PKT_LEN - 1);
    assign m_axis_tlast = m_axis_tvalid && last_beat;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) div_cnt <= '0;
        else div_cnt <= (div_cnt >= o_sample_div_eff - 32'd1) ? '0 : div_cnt + 32'd1;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        o_cs      = 1'b1;
        o_sclk    = 1'b1;
        o_busy    = state != IDLE;
        case (state)
            IDLE:    state_nxt = (tick && i_enable) ? CONVERT : IDLE;
            CONVERT: begin
                o_cs      = 1'b0;
                o_sclk    = ph >= PW'(SCLK_DIV);
                state_nxt = (period_end && last_bit) ? QUIET : CONVERT;
            end
            QUIET:   state_nxt = quiet_end ? IDLE : QUIET;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            ph <= '0;
            bc <= '0;
        end else if (state_nxt != state) begin
            ph <= '0;
            bc <= '0;
        end else if (state != IDLE) begin
            ph <= (state == CONVERT && period_end) ? '0 : ph + 1'b1;
            bc <= (state == CONVERT && period_end) ? bc + 1'b1 : bc;
        end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            for (int k = 0; k < NUM_CH; k++) sh[k] <= '0;
        end else if (shift) begin
            for (int k = 0; k < NUM_CH; k++) sh[k] <= {sh[k][ADC_BITS-2:0], i_data[k]};
        end

    always_comb begin
        sample = '0;
        for (int k = 0; k < NUM_CH; k++) sample[k*ADC_BITS +: ADC_BITS] = sh[k];
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            beat          <= '0;
            o_overrun     <= 1'b0;
        end else begin
            if (load && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= sample;
                m_axis_tvalid <= 1'b1;
            end else if (hs) begin
                m_axis_tvalid <= 1'b0;
            end
            if (hs) beat <= last_beat ? '0 : beat + 1'b1;
            // A fresh overrun beats a simultaneous clear
            if (load && m_axis_tvalid && !m_axis_tready) o_overrun <= 1'b1;
            else if (i_clr_overrun) o_overrun <= 1'b0;
        end
endmodule

// File: tb/tb_spi_adc_rx_multi.sv
// tb_spi_adc_rx_multi: directed bench with a behavioural two-channel ADC driving MISO from CS/SCLK
module tb_spi_adc_rx_multi;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_enable = 1'b0, m_axis_tready = 1'b1, i_clr_overrun = 1'b0;
    logic [1:0]  i_data = 2'b00;
    logic [31:0] i_sample_div = 32'd100;
    logic        o_cs, o_sclk, m_axis_tvalid, m_axis_tlast, o_overrun, o_busy;
    logic [31:0] o_sample_div_eff, eff4;
    logic [23:0] m_axis_tdata, tdata4;
    logic        cs4, sclk4, tvalid4, tlast4, ov4, busy4;

    spi_adc_rx_multi dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_data(i_data),
        .o_cs(o_cs), .o_sclk(o_sclk), .i_sample_div(i_sample_div), .o_sample_div_eff(o_sample_div_eff),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .o_overrun(o_overrun), .i_clr_overrun(i_clr_overrun), .o_busy(o_busy)
    );

    spi_adc_rx_multi #(.PKT_LEN(4)) dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_data(i_data),
        .o_cs(cs4), .o_sclk(sclk4), .i_sample_div(i_sample_div), .o_sample_div_eff(eff4),
        .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(tlast4), .o_overrun(ov4), .i_clr_overrun(i_clr_overrun), .o_busy(busy4)
    );

    always #5 i_clk = ~i_clk;

    // Frame words sent MSB first: {2 lead zeros, 12-bit sample, 2 trailing bits}
    logic [15:0] f0 = 16'h2970, f1 = 16'h048F;
    int          nf = 0, rises = 0, cyc = 0, n_tests = 0, n_fail = 0;
    logic        psclk = 1'b1, pcs = 1'b1, ptv = 1'b0;
    logic [63:0] beats[$];
    int          falls[$], tv_rises[$];
    logic        last4[$];
    logic [8:0]  lv;

    always @(posedge i_clk) cyc++;

    // ADC model: a new bit appears on CS fall and every SCLK fall; monitors share the same sampling point
    always @(negedge i_clk) begin
        if (o_cs) nf = 0;
        else if (!o_sclk && psclk) nf++;
        if (!o_cs && o_sclk && !psclk) rises++;
        if (!o_cs && pcs) falls.push_back(cyc);
        if (m_axis_tvalid && !ptv) tv_rises.push_back(cyc);
        if (m_axis_tvalid && m_axis_tready) beats.push_back(64'(m_axis_tdata));
        if (tvalid4 && m_axis_tready) last4.push_back(tlast4);
        psclk = o_sclk;
        pcs   = o_cs;
        ptv   = m_axis_tvalid;
        i_data = (nf == 0) ? 2'b00 : {f1[16-nf], f0[16-nf]};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_cs();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            cyc_n(1);
            ok = !o_cs;
        end
        chk("cs_fall_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        bit ok;
        cyc_n(3);
        chk("rst_ctrl", 64'({o_cs, o_sclk, m_axis_tvalid, m_axis_tlast, o_overrun, o_busy}), 64'b110000);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("eff_100", 64'(o_sample_div_eff), 64'd100);

        i_rst = 1'b0;
        i_enable = 1'b1;
        beats.delete(); falls.delete(); tv_rises.delete(); rises = 0;
        cyc_n(390);
        chk("t1_beats", 64'(beats.size()), 64'd3);
        foreach (beats[i]) chk("t1_data", beats[i], 64'h123A5C);
        chk("t1_period", 64'(falls[1] - falls[0]), 64'd100);
        chk("t1_latency", 64'(tv_rises[0] - falls[0]), 64'd66);
        chk("t1_sclk_pulses", 64'(rises), 64'd48);
        chk("t1_overrun", 64'(o_overrun), 64'd0);

        i_sample_div = 32'd10;
        #1;
        chk("t2_eff_min", 64'(o_sample_div_eff), 64'd68);
        beats.delete(); falls.delete();
        cyc_n(300);
        chk("t2_period", 64'(falls[2] - falls[1]), 64'd68);
        chk("t2_data", beats[1], 64'h123A5C);

        m_axis_tready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            cyc_n(1);
            ok = m_axis_tvalid;
        end
        chk("t3_valid_seen", 64'(ok), 64'd1);
        f0 = 16'h3FFC;
        f1 = 16'h0005;
        chk("t3_ov_before", 64'(o_overrun), 64'd0);
        cyc_n(224);
        chk("t3_held", 64'({m_axis_tvalid, m_axis_tdata}), 64'h1123A5C);
        chk("t3_ov_set", 64'(o_overrun), 64'd1);
        i_clr_overrun = 1'b1;
        cyc_n(1);
        i_clr_overrun = 1'b0;
        chk("t3_ov_clr", 64'(o_overrun), 64'd0);
        beats.delete();
        m_axis_tready = 1'b1;
        cyc_n(2);
        chk("t3_released", beats[0], 64'h123A5C);
        cyc_n(70);
        chk("t3_beats", 64'(beats.size()), 64'd2);
        chk("t3_new_data", beats[1], 64'h001FFF);

        i_rst = 1'b1;
        cyc_n(2);
        i_rst = 1'b0;
        beats.delete(); last4.delete();
        cyc_n(700);
        chk("t4_beats", 64'(last4.size()), 64'd9);
        lv = '0;
        foreach (last4[i]) if (i < 9) lv[i] = last4[i];
        chk("t4_tlast", 64'(lv), 64'b010001000);

        wait_cs();
        cyc_n(29);
        chk("t5_mid_frame", 64'({o_cs, o_busy}), 64'b01);
        i_rst = 1'b1;
        #1;
        chk("t5_rst_pins", 64'({o_cs, o_sclk, m_axis_tvalid, o_busy}), 64'b1100);
        cyc_n(2);
        f0 = 16'h2970;
        f1 = 16'h048F;
        beats.delete();
        i_rst = 1'b0;
        cyc_n(150);
        chk("t5_beats", 64'(beats.size()), 64'd1);
        chk("t5_data", beats[0], 64'h123A5C);

        wait_cs();
        cyc_n(10);
        i_enable = 1'b0;
        beats.delete(); falls.delete();
        cyc_n(250);
        chk("t6_beats", 64'(beats.size()), 64'd1);
        chk("t6_data", beats[0], 64'h123A5C);
        chk("t6_no_cs", 64'(falls.size()), 64'd0);
        chk("t6_idle", 64'({o_cs, o_busy}), 64'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
